// File: rtl/fma_pipe_ctl.sv
// Issue/writeback controller for the three-stage FMA datapath: stage valid/tag tracking,
// e2/e3 enables, a single-entry writeback buffer, and sticky fflags (built only with FMA_FFLAGS_ACC_EN).
module fma_pipe_ctl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_fp64,
    input  logic             flush,
    output logic             fma_e2_data_en,
    output logic             fma_e3_data_en,
    output logic             fma_fp64,
    input  logic [64:0]      fma_out_data,
    input  logic [4:0]       fma_out_exc,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_fp64,
    output logic [64:0]      wb_data,
    output logic [4:0]       wb_exc,
    output logic [4:0]       fflags_acc,
    input  logic             fflags_clr,
    output logic             busy
);

    logic             v2_q, v2_d, v3_q, v3_d, wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0] tag2_q, tag2_d, tag3_q, tag3_d, wb_tag_q, wb_tag_d;
    logic             fp64_2_q, fp64_2_d, fp64_3_q, fp64_3_d, wb_fp64_q, wb_fp64_d;
    logic [64:0]      wb_data_q, wb_data_d;
    logic [4:0]       wb_exc_q, wb_exc_d;

    logic out_free, adv3, e3_free, adv2, e2_free, accept;

    // A stage moves only when the stage downstream of it is empty or moving too.
    assign out_free = !wb_valid_q || wb_ready;
    assign adv3     = v3_q && out_free;
    assign e3_free  = !v3_q || adv3;
    assign adv2     = v2_q && e3_free;
    assign e2_free  = !v2_q || adv2;
    assign in_ready = e2_free && !flush;
    assign accept   = in_valid && in_ready;

    assign fma_e2_data_en = accept;
    assign fma_e3_data_en = adv2;
    assign fma_fp64       = v3_q && fp64_3_q;

    assign wb_valid = wb_valid_q;
    assign wb_tag   = wb_tag_q;
    assign wb_fp64  = wb_fp64_q;
    assign wb_data  = wb_data_q;
    assign wb_exc   = wb_exc_q;
    assign busy     = v2_q || v3_q || wb_valid_q;

    always_comb begin
        // NOTE: every _d starts at its hold value so no path through this block leaves it unassigned (no latch).
        v2_d       = v2_q;
        tag2_d     = tag2_q;
        fp64_2_d   = fp64_2_q;
        v3_d       = v3_q;
        tag3_d     = tag3_q;
        fp64_3_d   = fp64_3_q;
        wb_valid_d = wb_valid_q;
        wb_tag_d   = wb_tag_q;
        wb_fp64_d  = wb_fp64_q;
        wb_data_d  = wb_data_q;
        wb_exc_d   = wb_exc_q;

        if (accept) begin
            v2_d     = 1'b1;
            tag2_d   = in_tag;
            fp64_2_d = in_fp64;
        end else if (adv2) begin
            v2_d = 1'b0;
        end

        if (adv2) begin
            v3_d     = 1'b1;
            tag3_d   = tag2_q;
            fp64_3_d = fp64_2_q;
        end else if (adv3) begin
            v3_d = 1'b0;
        end

        if (adv3) begin
            wb_valid_d = 1'b1;
            wb_tag_d   = tag3_q;
            wb_fp64_d  = fp64_3_q;
            wb_data_d  = fma_out_data;
            wb_exc_d   = fma_out_exc;
        end else if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end

        // Valid bits alone mask stale payload, so flush leaves the data fields alone.
        if (flush) begin
            v2_d       = 1'b0;
            v3_d       = 1'b0;
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            v2_q       <= 1'b0;
            tag2_q     <= '0;
            fp64_2_q   <= 1'b0;
            v3_q       <= 1'b0;
            tag3_q     <= '0;
            fp64_3_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_fp64_q  <= 1'b0;
            wb_data_q  <= '0;
            wb_exc_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            v2_q       <= v2_d;
            tag2_q     <= tag2_d;
            fp64_2_q   <= fp64_2_d;
            v3_q       <= v3_d;
            tag3_q     <= tag3_d;
            fp64_3_q   <= fp64_3_d;
            wb_valid_q <= wb_valid_d;
            wb_tag_q   <= wb_tag_d;
            wb_fp64_q  <= wb_fp64_d;
            wb_data_q  <= wb_data_d;
            wb_exc_q   <= wb_exc_d;
        end
    end

`ifdef FMA_FFLAGS_ACC_EN
    logic       retire;
    logic [4:0] fflags_q, fflags_d;

    assign retire = wb_valid_q && wb_ready && !flush;

    // A clear that coincides with a retire keeps only the retiring op's flags.
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr) begin
            fflags_d = retire ? wb_exc_q : 5'd0;
        end else if (retire) begin
            fflags_d = fflags_q | wb_exc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            fflags_q <= 5'd0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_acc = fflags_q;
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr;
    assign fflags_acc        = 5'd0;
`endif

endmodule

// File: tb/tb_fma_pipe_ctl.sv
// Self-checking bench for fma_pipe_ctl: directed scenarios plus randomized traffic against a slot-based
// pipeline model; flag expectations follow FMA_FFLAGS_ACC_EN.
module tb_fma_pipe_ctl;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_l = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_fp64 = 1'b0;
    logic             flush = 1'b0;
    logic             fma_e2_data_en, fma_e3_data_en, fma_fp64;
    logic [64:0]      fma_out_data = '0;
    logic [4:0]       fma_out_exc = '0;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_fp64;
    logic [64:0]      wb_data;
    logic [4:0]       wb_exc;
    logic [4:0]       fflags_acc;
    logic             fflags_clr = 1'b0;
    logic             busy;

    fma_pipe_ctl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_l(rst_l),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_fp64(in_fp64),
        .flush(flush),
        .fma_e2_data_en(fma_e2_data_en), .fma_e3_data_en(fma_e3_data_en), .fma_fp64(fma_fp64),
        .fma_out_data(fma_out_data), .fma_out_exc(fma_out_exc),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_fp64(wb_fp64),
        .wb_data(wb_data), .wb_exc(wb_exc),
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: slot 1 = e2, slot 2 = e3, slot 3 = writeback buffer.
    typedef struct {
        bit               v;
        logic [TAG_W-1:0] tag;
        bit               fp64;
        logic [64:0]      data;
        logic [4:0]       exc;
    } op_t;

    op_t        slot [1:3];
    op_t        pend;
    bit         go [1:3];
    bit         m_acc;
    logic [4:0] m_flags;

    bit         e_in_ready, e_e2, e_e3, e_fp64, e_wbv, e_busy;
    logic [4:0] e_flags;

    int tests = 0;
    int fails = 0;

    task automatic model_clear();
        for (int k = 1; k <= 3; k++) begin
            slot[k].v    = 1'b0;
            slot[k].tag  = '0;
            slot[k].fp64 = 1'b0;
            slot[k].data = '0;
            slot[k].exc  = '0;
        end
        m_flags = 5'd0;
    endtask

    task automatic model_eval();
        go[3] = slot[3].v && wb_ready;
        for (int k = 2; k >= 1; k--) go[k] = slot[k].v && (!slot[k+1].v || go[k+1]);
        e_in_ready = (!slot[1].v || go[1]) && !flush;
        m_acc      = in_valid && e_in_ready;
        e_e2       = m_acc;
        e_e3       = go[1];
        e_fp64     = slot[2].v && slot[2].fp64;
        e_wbv      = slot[3].v;
        e_busy     = slot[1].v || slot[2].v || slot[3].v;
`ifdef FMA_FFLAGS_ACC_EN
        e_flags = m_flags;
`else
        e_flags = 5'd0;
`endif
    endtask

    task automatic model_update();
        bit retire;
        retire = slot[3].v && wb_ready && !flush;
        if (fflags_clr) m_flags = retire ? slot[3].exc : 5'd0;
        else if (retire) m_flags = m_flags | slot[3].exc;
        if (flush) begin
            for (int k = 1; k <= 3; k++) slot[k].v = 1'b0;
        end else begin
            for (int k = 3; k >= 2; k--) begin
                if (go[k-1]) slot[k] = slot[k-1];
                else if (go[k]) slot[k].v = 1'b0;
            end
            if (m_acc) slot[1] = pend;
            else if (go[1]) slot[1].v = 1'b0;
        end
    endtask

    // Called at a negedge: apply inputs, let them settle, refresh expectations.
    task automatic drive(input bit vld, input logic [TAG_W-1:0] tag, input bit fp,
                         input logic [4:0] exc, input bit wbr, input bit fl, input bit clr);
        in_valid   = vld;
        in_tag     = tag;
        in_fp64    = fp;
        wb_ready   = wbr;
        flush      = fl;
        fflags_clr = clr;
        pend.v     = 1'b1;
        pend.tag   = tag;
        pend.fp64  = fp;
        pend.data  = {$urandom, $urandom, 1'($urandom)};
        pend.exc   = exc;
        #1;
        model_eval();
    endtask

    // Clock edge, model step, then the datapath presents the e3 op's result.
    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        model_update();
        fma_out_data = slot[2].v ? slot[2].data : {$urandom, $urandom, 1'b0};
        fma_out_exc  = slot[2].v ? slot[2].exc : 5'($urandom);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, '0, 0, '0, 1, 0, 0);
        tests++;
        if ({in_ready, busy, wb_valid, fma_fp64, fma_e2_data_en, fma_e3_data_en} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {in_ready, busy, wb_valid, fma_fp64, fma_e2_data_en, fma_e3_data_en});
        end
        tests++;
        if ({wb_tag, wb_fp64, wb_data, wb_exc, fflags_acc} !== '0) begin
            fails++;
            $display("FAIL reset_payload: got tag=%h fp64=%b data=%h exc=%b fflags=%b expected all 0",
                     wb_tag, wb_fp64, wb_data, wb_exc, fflags_acc);
        end
    endtask

    task automatic test_single_op();
        drive(1, 5'd3, 1, 5'b00001, 1, 0, 0);
        tests++;
        if (fma_e2_data_en !== 1'b1) begin
            fails++;
            $display("FAIL single_e2_en: got %b expected 1", fma_e2_data_en);
        end
        tick();
        drive(0, '0, 0, '0, 1, 0, 0);
        tests++;
        if (fma_e3_data_en !== 1'b1) begin
            fails++;
            $display("FAIL single_e3_en: got %b expected 1", fma_e3_data_en);
        end
        tick();
        drive(0, '0, 0, '0, 1, 0, 0);
        tests++;
        if (fma_fp64 !== 1'b1) begin
            fails++;
            $display("FAIL single_fp64: got %b expected 1", fma_fp64);
        end
        tick();
        drive(0, '0, 0, '0, 1, 0, 0);
        tests++;
        if (!(wb_valid === 1'b1 && wb_tag === 5'd3 && wb_fp64 === 1'b1 && wb_data === slot[3].data)) begin
            fails++;
            $display("FAIL single_wb: got valid=%b tag=%0d fp64=%b data=%h expected 1/3/1/%h",
                     wb_valid, wb_tag, wb_fp64, wb_data, slot[3].data);
        end
        tick();
        drive(0, '0, 0, '0, 1, 0, 0);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 12; c++) begin
            drive(c < 8, 5'(c), c[0], 5'($urandom), 1, 0, 0);
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_in_ready c=%0d: got %b expected 1", c, in_ready);
            end
            if (c >= 3 && c < 11) begin
                tests++;
                if (!(wb_valid === 1'b1 && wb_tag === 5'(c - 3))) begin
                    fails++;
                    $display("FAIL stream_wb c=%0d: got valid=%b tag=%0d expected 1/%0d", c, wb_valid, wb_tag, c - 3);
                end
            end
            if (c == 11) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL stream_drain: got busy=%b expected 0", busy);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1, 5'(10 + accepted), 0, 5'b00010, 0, 0, 0);
            if (fma_e2_data_en === 1'b1) accepted++;
            tick();
        end
        drive(0, '0, 0, '0, 0, 0, 0);
        tests++;
        if (accepted != 3 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_fill: got accepted=%0d in_ready=%b expected 3/0", accepted, in_ready);
        end
        drive(1, 5'd13, 0, 5'b00010, 1, 0, 0);
        tests++;
        if (!(in_ready === 1'b1 && wb_valid === 1'b1 && wb_tag === 5'd10)) begin
            fails++;
            $display("FAIL bp_release: got in_ready=%b valid=%b tag=%0d expected 1/1/10", in_ready, wb_valid, wb_tag);
        end
        tick();
        for (int r = 1; r <= 3; r++) begin
            drive(0, '0, 0, '0, 1, 0, 0);
            tests++;
            if (!(wb_valid === 1'b1 && wb_tag === 5'(10 + r))) begin
                fails++;
                $display("FAIL bp_order r=%0d: got valid=%b tag=%0d expected 1/%0d", r, wb_valid, wb_tag, 10 + r);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [4:0] flags_before;
        for (int c = 0; c < 3; c++) begin
            drive(1, 5'(20 + c), 0, 5'b01010, 0, 0, 0);
            tick();
        end
        drive(1, 5'd9, 0, '0, 1, 1, 0);
        flags_before = e_flags;
        tests++;
        if (!(in_ready === 1'b0 && fma_e2_data_en === 1'b0 && busy === 1'b1)) begin
            fails++;
            $display("FAIL flush_cycle: got in_ready=%b e2_en=%b busy=%b expected 0/0/1", in_ready, fma_e2_data_en, busy);
        end
        tick();
        drive(0, '0, 0, '0, 0, 0, 0);
        tests++;
        if (!(wb_valid === 1'b0 && busy === 1'b0 && fflags_acc === flags_before)) begin
            fails++;
            $display("FAIL flush_after: got valid=%b busy=%b fflags=%b expected 0/0/%b",
                     wb_valid, busy, fflags_acc, flags_before);
        end
    endtask

    task automatic test_flags();
`ifdef FMA_FFLAGS_ACC_EN
        localparam logic [4:0] FL_AB = 5'b10001;
        localparam logic [4:0] FL_C  = 5'b00100;
`else
        localparam logic [4:0] FL_AB = 5'b00000;
        localparam logic [4:0] FL_C  = 5'b00000;
`endif
        drive(0, '0, 0, '0, 1, 0, 1);
        tick();
        drive(1, 5'd1, 0, 5'b00001, 1, 0, 0);
        tick();
        drive(1, 5'd2, 1, 5'b10000, 1, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, '0, 0, '0, 1, 0, 0);
            tick();
        end
        drive(1, 5'd3, 0, 5'b00100, 1, 0, 0);
        tests++;
        if (fflags_acc !== FL_AB) begin
            fails++;
            $display("FAIL flags_accum: got %b expected %b", fflags_acc, FL_AB);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(0, '0, 0, '0, 1, 0, 0);
            tick();
        end
        drive(0, '0, 0, '0, 1, 0, 1);
        tests++;
        if (!(wb_valid === 1'b1 && wb_exc === 5'b00100)) begin
            fails++;
            $display("FAIL flags_wb_exc: got valid=%b exc=%b expected 1/00100", wb_valid, wb_exc);
        end
        tick();
        drive(0, '0, 0, '0, 1, 0, 0);
        tests++;
        if (fflags_acc !== FL_C) begin
            fails++;
            $display("FAIL flags_clr_retire: got %b expected %b", fflags_acc, FL_C);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(99) < 70, 5'($urandom), 1'($urandom), 5'($urandom),
                  $urandom_range(99) < 65, $urandom_range(99) < 4, $urandom_range(99) < 5);
            tests++;
            if ({in_ready, fma_e2_data_en, fma_e3_data_en, fma_fp64, wb_valid, busy} !==
                {e_in_ready, e_e2, e_e3, e_fp64, e_wbv, e_busy}) begin
                fails++;
                $display("FAIL rand_ctrl c=%0d: got %b expected %b", c,
                         {in_ready, fma_e2_data_en, fma_e3_data_en, fma_fp64, wb_valid, busy},
                         {e_in_ready, e_e2, e_e3, e_fp64, e_wbv, e_busy});
            end
            tests++;
            if (fflags_acc !== e_flags) begin
                fails++;
                $display("FAIL rand_fflags c=%0d: got %b expected %b", c, fflags_acc, e_flags);
            end
            if (e_wbv) begin
                tests++;
                if ({wb_tag, wb_fp64, wb_exc, wb_data} !== {slot[3].tag, slot[3].fp64, slot[3].exc, slot[3].data}) begin
                    fails++;
                    $display("FAIL rand_wb c=%0d: got tag=%0d fp64=%b exc=%b data=%h expected %0d/%b/%b/%h", c,
                             wb_tag, wb_fp64, wb_exc, wb_data, slot[3].tag, slot[3].fp64, slot[3].exc, slot[3].data);
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1, 5'(24 + c), 1, 5'b11111, 0, 0, 0);
            tick();
        end
        drive(1, 5'd30, 1, 5'b11111, 0, 0, 0);
        tests++;
        if ({busy, in_ready, wb_valid} !== 3'b101) begin
            fails++;
            $display("FAIL areset_full: got busy/in_ready/wb_valid=%b expected 101", {busy, in_ready, wb_valid});
        end
        in_valid = 1'b0;
        #2;
        rst_l = 1'b0;
        #1;
        tests++;
        if ({in_ready, busy, wb_valid, fma_fp64, fma_e2_data_en, fma_e3_data_en} !== 6'b100000) begin
            fails++;
            $display("FAIL areset_ctrl: got %b expected 100000",
                     {in_ready, busy, wb_valid, fma_fp64, fma_e2_data_en, fma_e3_data_en});
        end
        tests++;
        if ({wb_tag, wb_fp64, wb_data, wb_exc, fflags_acc} !== '0) begin
            fails++;
            $display("FAIL areset_payload: got tag=%h fp64=%b data=%h exc=%b fflags=%b expected all 0",
                     wb_tag, wb_fp64, wb_data, wb_exc, fflags_acc);
        end
        model_clear();
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        pend = slot[1];
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_backpressure();
        repeat (4) begin
            drive(0, '0, 0, '0, 1, 0, 0);
            tick();
        end
        test_flush();
        test_flags();
        test_random();
        test_async_reset();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fma_pipe_ctl.md
# fma_pipe_ctl

Issue/writeback controller for the three-stage floating-point fused multiply-add datapath: it accepts FMA operations from the FP issue logic, drives the datapath's e2/e3 stage-register enables and its output precision select, and collects the rounded recoded result and exception flags into a single-entry writeback buffer with a valid/ready handshake. It also tracks per-stage valid, tag and precision, handles flush and back-pressure, and accumulates sticky FP exception flags.

## Interface
- TAG_W, 5, width of the destination tag carried with each operation
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- in_valid  in  1  issue request; operands/ctrl_code/rm are presented to the datapath in this cycle
- in_ready  out  1  controller can accept this cycle
- in_tag  in  TAG_W  destination tag
- in_fp64  in  1  1 = double, 0 = single
- flush  in  1  kill all in-flight operations, including the writeback buffer
- fma_e2_data_en  out  1  datapath e1→e2 register enable
- fma_e3_data_en  out  1  datapath e2→e3 register enable
- fma_fp64  out  1  datapath output precision select; equals the e3 operation's precision
- fma_out_data  in  65  recoded result from the datapath; valid whenever e3 holds an operation
- fma_out_exc  in  5  exception flags from the datapath
- wb_valid  out  1  writeback buffer holds a result
- wb_ready  in  1  consumer takes the result
- wb_tag  out  TAG_W  tag of the buffered result
- wb_fp64  out  1  precision of the buffered result
- wb_data  out  65  buffered recoded result
- wb_exc  out  5  buffered exception flags {NV,DZ,OF,UF,NX}
- fflags_acc  out  5  sticky OR of retired exception flags
- fflags_clr  in  1  clear fflags_acc
- busy  out  1  v2 | v3 | wb_valid

## Operation
- State: v2/tag2/fp64_2 (e2), v3/tag3/fp64_3 (e3), wb_valid plus wb_tag/wb_fp64/wb_data/wb_exc (writeback buffer), fflags_acc.
- Advance equations, all combinational:
  - out_free = !wb_valid | wb_ready
  - adv3 = v3 & out_free
  - e3_free = !v3 | adv3
  - adv2 = v2 & e3_free
  - e2_free = !v2 | adv2
  - in_ready = e2_free & !flush
  - accept = in_valid & in_ready
- fma_e2_data_en = accept. fma_e3_data_en = adv2. A stalled stage holds its datapath registers and its own state.
- On accept: v2←1 and tag2/fp64_2 ← inputs. Otherwise, if adv2, v2←0.
- On adv2: v3←1 and tag3/fp64_3 ← e2 values. Otherwise, if adv3, v3←0.
- On adv3: wb_valid←1 and wb_data/wb_exc ← fma_out_data/fma_out_exc, wb_tag/wb_fp64 ← tag3/fp64_3.
- On wb_valid & wb_ready without adv3: wb_valid←0. wb_* fields hold while wb_valid is set and not taken.
- fma_fp64 = fp64_3; it is 0 when v3 = 0.
- Flush overrides all of the above: v2, v3 and wb_valid ←0 at the edge; in_ready = 0 in the flush cycle; a wb handshake in the flush cycle does not retire, so no flag accumulation. Datapath registers are not cleared, since valid bits mask them.
- fflags update, in priority order:
  - clr without retire: 0
  - clr with retire: wb_exc
  - retire alone: fflags_acc | wb_exc
  - A retire is wb_valid & wb_ready & !flush.

## Timing
- Reset: all valid bits 0, tags/fp64/wb_data/wb_exc 0, fflags_acc 0. After reset in_ready = 1 and busy = 0.
- Latency: accept in cycle N, v2 in N+1, v3 and datapath result in N+2, wb_valid in N+3.
- Throughput: one operation per cycle while wb_ready = 1.
- Back-pressure: wb_ready low with the buffer full fills e3 then e2. in_ready drops in the cycle when v2 & v3 & wb_valid & !wb_ready.
- With a full pipe, wb_ready rising moves all stages and accepts a new input in that same cycle; no bubble.
- Simultaneous accept and adv2 in one cycle is a normal shift.
- Reset asserted mid-operation asynchronously clears all state; operations in flight are lost with no writeback.

## Configuration
- FMA_FFLAGS_ACC_EN defined: the fflags_acc register and fflags_clr behaviour are present as above.
- Not defined: fflags_acc is tied to 0, fflags_clr is ignored, and no accumulator flops are built. wb_exc is unaffected.

## Test plan
- Single op: accept tag 3, fp64 = 1, with wb_ready = 1. Required: fma_e2_data_en in N, fma_e3_data_en in N+1, fma_fp64 = 1 in N+2, wb_valid with wb_tag = 3 in N+3, busy = 0 in N+4.
- Stream of tags 0..7 back-to-back with wb_ready = 1. Required: in_ready stays 1, and wb_tag 0..7 appears in 8 consecutive cycles starting 3 cycles after the first accept.
- wb_ready held 0 with continuous in_valid. Required: exactly 3 ops accepted, then in_ready = 0. Releasing wb_ready retires one op per cycle in order, and in_ready returns in the same cycle.
- Flush with 3 ops in flight and wb_ready = 0. Required: the next cycle shows wb_valid = 0 and busy = 0; no retire and no fflags change; in_ready = 0 during the flush cycle.
- Flags: two ops retire with exc 5'b00001 then 5'b10000, giving fflags_acc = 5'b10001. Then fflags_clr asserted together with a retire of 5'b00100 gives fflags_acc = 5'b00100. With FMA_FFLAGS_ACC_EN undefined, fflags_acc stays 0 throughout.
- Assert rst_l low during a stall with a full pipe. Required: all outputs at their reset values immediately, without waiting for a clock edge.
